// File: rtl/vslc_pkg.sv
// -----------------------------------------------------------------------------
// vslc_pkg
// Shared constants and types for the VSLC instruction-fetch stage.
//   EEPROM_READ_INSTR : SPI EEPROM sequential-read opcode
//   VSLC_ADDR_W       : default program address width
//   fetch_state_t     : fetch FSM state encoding (also exported for debug)
// -----------------------------------------------------------------------------
package vslc_pkg;

   localparam logic [7:0] EEPROM_READ_INSTR = 8'h03;
   localparam int         VSLC_ADDR_W       = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CS_GAP = 3'd1,
      ST_CMD    = 3'd2,
      ST_ADDRH  = 3'd3,
      ST_ADDRL  = 3'd4,
      ST_STREAM = 3'd5
   } fetch_state_t;

endpackage

// File: rtl/vslc_spi_fetch_if.sv
// -----------------------------------------------------------------------------
// vslc_spi_fetch_if
// Core-side bus of the fetch stage.
//   restart_valid / restart_addr : one-cycle request to restart fetching
//   byte_valid / byte_ready      : byte handshake
//   byte_data / byte_addr        : head byte and its EEPROM address
//   busy                         : fetch stage not idle
// Handshake: byte_valid/byte_data/byte_addr are driven by the fetch stage and
// stay stable until accepted; a byte is transferred on the rising clk edge where
// byte_valid and byte_ready are both high. byte_valid never depends on
// byte_ready. restart_valid is a single-cycle pulse with no ready; it is always
// accepted and overrides a transfer on the same edge.
// Modports: master = core side, slave = fetch stage.
// -----------------------------------------------------------------------------
interface vslc_spi_fetch_if #(
   parameter int ADDR_W = vslc_pkg::VSLC_ADDR_W
);
   logic              restart_valid;
   logic [ADDR_W-1:0] restart_addr;
   logic              byte_valid;
   logic              byte_ready;
   logic [7:0]        byte_data;
   logic [ADDR_W-1:0] byte_addr;
   logic              busy;

   modport master (
      output restart_valid, restart_addr, byte_ready,
      input  byte_valid, byte_data, byte_addr, busy
   );

   modport slave (
      input  restart_valid, restart_addr, byte_ready,
      output byte_valid, byte_data, byte_addr, busy
   );
endinterface

// File: rtl/vslc_byte_fifo.sv
// -----------------------------------------------------------------------------
// vslc_byte_fifo
// Small synchronous prefetch FIFO ({byte, address} entries).
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (accepted when not full, or full with pop)
//   pop         : drop head (ignored when empty)
//   flush       : empty the FIFO; overrides push and pop on the same edge
//   head_data   : head entry, zero while empty
//   head_valid  : FIFO not empty
//   count       : number of stored entries
// -----------------------------------------------------------------------------
module vslc_byte_fifo #(
   parameter  int W     = 18,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [W-1:0]     head_data,
   output logic             head_valid,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign head_valid = (count != '0);
   assign pop_ok     = pop && head_valid && !flush;
   // A full FIFO can still take a push when the head leaves on the same edge.
   assign push_ok    = push && !flush && ((count != CNT_W'(DEPTH)) || pop_ok);
   assign head_data  = head_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end
endmodule

// File: rtl/vslc_spi_fetch.sv
// -----------------------------------------------------------------------------
// vslc_spi_fetch
// Instruction-fetch stage: reads program bytes from an SPI mode-0 EEPROM
// (READ + 16-bit address, then sequential read) into a prefetch FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset
//   fetch        : core-side bus (restart request, byte handshake, busy)
//   spi_cs_n     : EEPROM chip select, active low
//   spi_sck      : SPI clock, idles low
//   spi_copi     : controller-out data
//   spi_cipo     : controller-in data
//   state_dbg    : current fetch FSM state
// -----------------------------------------------------------------------------
module vslc_spi_fetch
   import vslc_pkg::*;
#(
   parameter int ADDR_W     = VSLC_ADDR_W,
   parameter int FIFO_DEPTH = 2,
   parameter int SCK_DIV    = 1,
   parameter int CS_GAP_CYC = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   vslc_spi_fetch_if.slave     fetch,
   output logic                spi_cs_n,
   output logic                spi_sck,
   output logic                spi_copi,
   input  logic                spi_cipo,
   output fetch_state_t        state_dbg
);
   localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int GAP_W = (CS_GAP_CYC > 0) ? $clog2(CS_GAP_CYC + 1) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

   fetch_state_t      state;
   logic [7:0]        tx_sr;
   logic [7:0]        rx_sr;
   logic [2:0]        bit_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [ADDR_W-1:0] fetch_addr;
   logic [15:0]       addr16;
   logic              push_now;
   logic              fifo_pop;
   logic              fifo_full;
   logic [CNT_W-1:0]  fifo_count;
   logic [7+ADDR_W:0] fifo_head;

   assign addr16    = 16'(fetch_addr);
   assign spi_copi  = tx_sr[7];
   assign state_dbg = state;
   assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign fifo_pop  = fetch.byte_valid && fetch.byte_ready;

   assign fetch.busy      = (state != ST_IDLE);
   assign fetch.byte_data = fifo_head[7+ADDR_W:ADDR_W];
   assign fetch.byte_addr = fifo_head[ADDR_W-1:0];

   // A stream byte is complete on the SCK fall that follows its 8th sample.
   always_comb begin
      push_now = 1'b0;
      if (!fetch.restart_valid && state == ST_STREAM && div_cnt == DIV_LAST &&
          spi_sck && bit_cnt == 3'd0) begin
         push_now = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         spi_cs_n   <= 1'b1;
         spi_sck    <= 1'b0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= 3'd7;
         div_cnt    <= '0;
         gap_cnt    <= '0;
         fetch_addr <= '0;
      end else if (fetch.restart_valid) begin
         // Restart aborts whatever is in flight, from any state.
         state      <= ST_CS_GAP;
         spi_cs_n   <= 1'b1;
         spi_sck    <= 1'b0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= 3'd7;
         div_cnt    <= '0;
         gap_cnt    <= GAP_W'(CS_GAP_CYC);
         fetch_addr <= fetch.restart_addr;
      end else begin
         case (state)
            ST_IDLE: begin
            end
            ST_CS_GAP: begin
               if (gap_cnt == '0) begin
                  state    <= ST_CMD;
                  spi_cs_n <= 1'b0;
                  tx_sr    <= EEPROM_READ_INSTR;
                  bit_cnt  <= 3'd7;
                  div_cnt  <= '0;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            ST_CMD, ST_ADDRH, ST_ADDRL, ST_STREAM: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 1'b1;
               end else if (!spi_sck) begin
                  // Rising SCK: a new stream byte only starts when it has a free
                  // FIFO slot; otherwise SCK parks low with the divider at its
                  // terminal count so the byte starts on the first edge with space.
                  if (!(state == ST_STREAM && bit_cnt == 3'd7 && fifo_full)) begin
                     spi_sck <= 1'b1;
                     div_cnt <= '0;
                     rx_sr   <= {rx_sr[6:0], spi_cipo};
                  end
               end else begin
                  // Falling SCK: advance COPI while SCK is low.
                  spi_sck <= 1'b0;
                  div_cnt <= '0;
                  if (bit_cnt != 3'd0) begin
                     bit_cnt <= bit_cnt - 3'd1;
                     tx_sr   <= {tx_sr[6:0], 1'b0};
                  end else begin
                     bit_cnt <= 3'd7;
                     case (state)
                        ST_CMD: begin
                           state <= ST_ADDRH;
                           tx_sr <= addr16[15:8];
                        end
                        ST_ADDRH: begin
                           state <= ST_ADDRL;
                           tx_sr <= addr16[7:0];
                        end
                        ST_ADDRL: begin
                           state <= ST_STREAM;
                           tx_sr <= '0;
                        end
                        default: begin
                           // Byte pushed this edge (push_now); move to the next address.
                           fetch_addr <= fetch_addr + 1'b1;
                           tx_sr      <= '0;
                        end
                     endcase
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   vslc_byte_fifo #(
      .W     (8 + ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_now),
      .push_data  ({rx_sr, fetch_addr}),
      .pop        (fifo_pop),
      .flush      (fetch.restart_valid),
      .head_data  (fifo_head),
      .head_valid (fetch.byte_valid),
      .count      (fifo_count)
   );
endmodule
